// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the DMA priority resolver:
//   NUM_CH        - number of DMA channels (4)
//   ch_t          - channel index / rotating-priority pointer type (2 bits)
//   state_t       - arbitration state (IDLE, GRANT, SERVICE)
//   onehot_to_ch  - converts a one-hot channel vector to its channel index
// ---------------------------------------------------------------------------
package dma_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Index of the set bit in a one-hot vector; returns 0 for an all-zero input.
    function automatic ch_t onehot_to_ch(input logic [NUM_CH-1:0] oh);
        ch_t idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) begin
                idx = ch_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// ---------------------------------------------------------------------------
// dma_prio_encoder
// Combinational rotating-priority encoder. The search starts at channel
// `ptr` and proceeds upward modulo NUM_CH; the first requesting channel wins.
// Ports:
//   req   in  [NUM_CH-1:0]  effective request vector
//   ptr   in  ch_t          highest-priority channel for this search
//   grant out [NUM_CH-1:0]  one-hot winner (all zero when no request)
//   valid out               at least one request present
// ---------------------------------------------------------------------------
module dma_prio_encoder
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_t               ptr,
    output logic [NUM_CH-1:0] grant,
    output logic              valid
);

    // Requests rotated so that position 0 is the channel at ptr; this lets a
    // plain lowest-set-bit pick implement the circular search.
    logic [NUM_CH-1:0] rot_req;
    logic [NUM_CH-1:0] rot_first;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rotate
            ch_t src_idx;
            // 2-bit addition wraps, giving the modulo-4 channel order for free
            assign src_idx     = ptr + ch_t'(gi);
            assign rot_req[gi] = req[src_idx];
        end
    endgenerate

    // Isolate the lowest set bit of the rotated vector
    assign rot_first = rot_req & (~rot_req + {{(NUM_CH-1){1'b0}}, 1'b1});

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unrotate
            ch_t rot_idx;
            assign rot_idx   = ch_t'(gi) - ptr;
            assign grant[gi] = rot_first[rot_idx];
        end
    endgenerate

    assign valid = |req;

endmodule

// File: rtl/dma_priority_resolver.sv
// ---------------------------------------------------------------------------
// dma_priority_resolver
// Four-channel DMA request arbiter with fixed or rotating priority.
// Ports:
//   CLK               in   system clock, rising edge
//   RESET             in   synchronous active-low reset
//   DREQ[3:0]         in   external channel requests (async, polarity by cmdDreqSenseLow)
//   cmdDreqSenseLow   in   1 = DREQ active-low
//   cmdDackSenseHigh  in   1 = DACK active-high
//   cmdRotate         in   1 = rotating priority, 0 = fixed (ch0 highest)
//   cmdDisable        in   blocks new grants
//   maskReg[3:0]      in   hardware request mask (1 = masked)
//   reqReg[3:0]       in   software requests (never masked)
//   hrq               in   hold request (informational only)
//   validDACK         in   timing control: granted channel is in service
//   VALID_DREQ0..3    out  one-hot granted channel
//   DACK[3:0]         out  channel acknowledges, polarity by cmdDackSenseHigh
//   reqStatus[3:0]    out  registered unmasked request bits
// ---------------------------------------------------------------------------
module dma_priority_resolver
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              cmdDreqSenseLow,
    input  logic              cmdDackSenseHigh,
    input  logic              cmdRotate,
    input  logic              cmdDisable,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] reqReg,
    input  logic              hrq,
    input  logic              validDACK,
    output logic              VALID_DREQ0,
    output logic              VALID_DREQ1,
    output logic              VALID_DREQ2,
    output logic              VALID_DREQ3,
    output logic [NUM_CH-1:0] DACK,
    output logic [NUM_CH-1:0] reqStatus
);

    state_t            state_reg, state_next;
    ch_t               ptr_reg, ptr_next;
    logic [NUM_CH-1:0] grant_reg, grant_next;
    logic [NUM_CH-1:0] sampled_reg;
    logic [NUM_CH-1:0] status_reg;

    logic [NUM_CH-1:0] dreq_norm;
    logic [NUM_CH-1:0] eff_req;
    logic [NUM_CH-1:0] enc_grant;
    logic              enc_valid;
    ch_t               grant_ch;
    logic [NUM_CH-1:0] dack_active;

    // hrq does not take part in arbitration
    logic unused_hrq;
    assign unused_hrq = hrq;

    assign dreq_norm = cmdDreqSenseLow ? ~DREQ : DREQ;
    assign eff_req   = (sampled_reg & ~maskReg) | reqReg;
    assign grant_ch  = onehot_to_ch(grant_reg);

    dma_prio_encoder u_prio_encoder (
        .req   (eff_req),
        .ptr   (ptr_reg),
        .grant (enc_grant),
        .valid (enc_valid)
    );

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                if (!cmdDisable && enc_valid) begin
                    grant_next = enc_grant;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (validDACK) begin
                    state_next = ST_SERVICE;
                end else if (!(|(eff_req & grant_reg))) begin
                    // Requester withdrew before being serviced: abandon the
                    // grant without touching the priority pointer.
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
            end
            ST_SERVICE: begin
                // Grant is held here regardless of DREQ/mask/disable changes
                if (!validDACK) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    ptr_next   = cmdRotate ? (grant_ch + 2'd1) : '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
        // Fixed priority always searches from channel 0; this also makes a
        // 1->0 change of cmdRotate take effect on the next edge.
        if (!cmdRotate) begin
            ptr_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            grant_reg   <= '0;
            sampled_reg <= '0;
            status_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            sampled_reg <= dreq_norm;
            status_reg  <= dreq_norm | reqReg;
        end
    end

    assign VALID_DREQ0 = grant_reg[0];
    assign VALID_DREQ1 = grant_reg[1];
    assign VALID_DREQ2 = grant_reg[2];
    assign VALID_DREQ3 = grant_reg[3];

    assign dack_active = (state_reg == ST_SERVICE) ? grant_reg : '0;
    assign DACK        = cmdDackSenseHigh ? dack_active : ~dack_active;
    assign reqStatus   = status_reg;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// ---------------------------------------------------------------------------
// tb_dma_priority_resolver
// Self-checking bench: directed scenarios with literal expectations, then
// randomized stimulus compared every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_dma_priority_resolver;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic       cmdDreqSenseLow;
    logic       cmdDackSenseHigh;
    logic       cmdRotate;
    logic       cmdDisable;
    logic [3:0] maskReg;
    logic [3:0] reqReg;
    logic       hrq;
    logic       validDACK;
    logic       VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3;
    logic [3:0] DACK;
    logic [3:0] reqStatus;
    logic [3:0] valid_vec;

    assign valid_vec = {VALID_DREQ3, VALID_DREQ2, VALID_DREQ1, VALID_DREQ0};

    dma_priority_resolver dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .DREQ             (DREQ),
        .cmdDreqSenseLow  (cmdDreqSenseLow),
        .cmdDackSenseHigh (cmdDackSenseHigh),
        .cmdRotate        (cmdRotate),
        .cmdDisable       (cmdDisable),
        .maskReg          (maskReg),
        .reqReg           (reqReg),
        .hrq              (hrq),
        .validDACK        (validDACK),
        .VALID_DREQ0      (VALID_DREQ0),
        .VALID_DREQ1      (VALID_DREQ1),
        .VALID_DREQ2      (VALID_DREQ2),
        .VALID_DREQ3      (VALID_DREQ3),
        .DACK             (DACK),
        .reqStatus        (reqStatus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Granted channel (-1 = none), whether it is in service, search start,
    // and the one-cycle-delayed request samples.
    int       m_gch   = -1;
    bit       m_serv  = 1'b0;
    int       m_ptr   = 0;
    bit [3:0] m_samp  = '0;
    bit [3:0] m_stat  = '0;

    always @(posedge CLK) begin
        bit [3:0] eff;
        bit [3:0] norm;
        bit       found;
        eff  = (m_samp & ~maskReg) | reqReg;
        norm = cmdDreqSenseLow ? ~DREQ : DREQ;
        if (!RESET) begin
            m_gch  = -1;
            m_serv = 1'b0;
            m_ptr  = 0;
            m_samp = '0;
            m_stat = '0;
        end else begin
            if (m_gch < 0) begin
                found = 1'b0;
                if (!cmdDisable) begin
                    for (int k = 0; k < 4; k++) begin
                        if (!found && eff[(m_ptr + k) % 4]) begin
                            m_gch = (m_ptr + k) % 4;
                            found = 1'b1;
                        end
                    end
                end
            end else if (!m_serv) begin
                if (validDACK)         m_serv = 1'b1;
                else if (!eff[m_gch])  m_gch  = -1;
            end else if (!validDACK) begin
                m_ptr  = cmdRotate ? (m_gch + 1) % 4 : 0;
                m_gch  = -1;
                m_serv = 1'b0;
            end
            if (!cmdRotate) m_ptr = 0;
            m_samp = norm;
            m_stat = norm | reqReg;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        logic [3:0] exp_valid;
        logic [3:0] exp_act;
        if (chk_en) begin
            exp_valid = (m_gch >= 0) ? (4'b0001 << m_gch) : 4'b0000;
            exp_act   = m_serv ? exp_valid : 4'b0000;
            check("model_valid", valid_vec, exp_valid);
            check("model_dack", DACK, cmdDackSenseHigh ? exp_act : ~exp_act);
            check("model_reqstatus", reqStatus, m_stat);
            check("onehot", {3'b000, ($countones(valid_vec) > 1)}, 4'b0000);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0; DREQ = 4'b1111; cmdDreqSenseLow = 1'b0; cmdDackSenseHigh = 1'b1;
        cmdRotate = 1'b0; cmdDisable = 1'b0; maskReg = '0; reqReg = 4'b1111;
        hrq = 1'b0; validDACK = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check("reset_valid", valid_vec, 4'b0000);
        check("reset_status", reqStatus, 4'b0000);
        check("reset_dack", DACK, 4'b0000);
        DREQ = 4'b0000; reqReg = 4'b0000; RESET = 1'b1;
        tick(2);

        // Fixed mode, two-cycle grant latency, DACK only in service
        DREQ = 4'b1010;
        tick(1); check("fix_lat1", valid_vec, 4'b0000);
        tick(1); check("fix_grant1", valid_vec, 4'b0010);
        check("fix_status", reqStatus, 4'b1010);
        validDACK = 1'b1;
        tick(1); check("fix_dack1", DACK, 4'b0010);
        validDACK = 1'b0; DREQ = 4'b0000;
        tick(1); check("fix_idle", valid_vec, 4'b0000);
        DREQ = 4'b1111;
        tick(2); check("fix_ptr0", valid_vec, 4'b0001);
        validDACK = 1'b1; tick(1);
        validDACK = 1'b0; DREQ = 4'b0000; tick(3);

        // Rotate mode: serve ch2, then 3, then wrap to 0
        cmdRotate = 1'b1; DREQ = 4'b0100;
        tick(2); check("rot_grant2", valid_vec, 4'b0100);
        validDACK = 1'b1; tick(1);
        validDACK = 1'b0; DREQ = 4'b1111;
        tick(1); check("rot_gap", valid_vec, 4'b0000);
        tick(1); check("rot_grant3", valid_vec, 4'b1000);
        validDACK = 1'b1; tick(1);
        validDACK = 1'b0;
        tick(1); check("rot_gap2", valid_vec, 4'b0000);
        tick(1); check("rot_wrap0", valid_vec, 4'b0001);
        DREQ = 4'b0000; tick(3);
        cmdRotate = 1'b0; tick(1);

        // Mask vs software request
        maskReg = 4'b0001; DREQ = 4'b0001; reqReg = 4'b0001;
        tick(2); check("mask_swreq", valid_vec, 4'b0001);
        reqReg = 4'b0000;
        tick(1); check("mask_drop", valid_vec, 4'b0000);
        check("mask_status", reqStatus, 4'b0001);
        tick(2); check("mask_nogrant", valid_vec, 4'b0000);
        maskReg = 4'b0000; DREQ = 4'b0000; tick(2);

        // Withdrawn request before validDACK
        DREQ = 4'b0010;
        tick(2); check("wd_grant", valid_vec, 4'b0010);
        DREQ = 4'b0000;
        tick(1); check("wd_hold", valid_vec, 4'b0010);
        tick(1); check("wd_idle", valid_vec, 4'b0000);
        DREQ = 4'b1111;
        tick(2); check("wd_ptr", valid_vec, 4'b0001);
        DREQ = 4'b0000; tick(3);

        // Disable during service
        DREQ = 4'b0100;
        tick(2); check("dis_grant", valid_vec, 4'b0100);
        validDACK = 1'b1; tick(1);
        cmdDisable = 1'b1;
        tick(1); check("dis_dack", DACK, 4'b0100);
        validDACK = 1'b0; DREQ = 4'b1111;
        tick(1); check("dis_exit", valid_vec, 4'b0000);
        tick(3); check("dis_block", valid_vec, 4'b0000);
        cmdDisable = 1'b0;
        tick(1); check("dis_release", valid_vec, 4'b0001);
        DREQ = 4'b0000; tick(3);

        // Reset in service, active-low DACK
        cmdDackSenseHigh = 1'b0; DREQ = 4'b0001;
        tick(2); check("rst_grant", valid_vec, 4'b0001);
        validDACK = 1'b1;
        tick(1); check("rst_dack_on", DACK, 4'b1110);
        RESET = 1'b0;
        tick(1); check("rst_dack_off", DACK, 4'b1111);
        check("rst_valid", valid_vec, 4'b0000);
        check("rst_status", reqStatus, 4'b0000);
        RESET = 1'b1; validDACK = 1'b0; DREQ = 4'b0000; cmdDackSenseHigh = 1'b1;
        tick(2);

        // Randomized phase against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) DREQ = 4'($urandom);
            maskReg   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            reqReg    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 49) == 0) cmdRotate = ~cmdRotate;
            if ($urandom_range(0, 99) == 0) cmdDreqSenseLow = ~cmdDreqSenseLow;
            if ($urandom_range(0, 99) == 0) cmdDackSenseHigh = ~cmdDackSenseHigh;
            cmdDisable = ($urandom_range(0, 9) == 0);
            validDACK  = 1'($urandom_range(0, 1));
            hrq        = 1'($urandom_range(0, 1));
            RESET      = ($urandom_range(0, 199) != 0);
            tick(1);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_priority_resolver.md
DMA_PRIORITY_RESOLVER -- requirements
Module: dma_priority_resolver

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-low reset, sampled on CLK rising edge.
REQ-003 SHALL have port DREQ  input  4  external channel requests, asynchronous, polarity per cmdDreqSenseLow.
REQ-004 SHALL have port cmdDreqSenseLow  input  1  1 = DREQ active-low, 0 = active-high.
REQ-005 SHALL have port cmdDackSenseHigh  input  1  1 = DACK active-high, 0 = active-low.
REQ-006 SHALL have port cmdRotate  input  1  1 = rotating priority, 0 = fixed (ch0 highest).
REQ-007 SHALL have port cmdDisable  input  1  controller disable; blocks new grants.
REQ-008 SHALL have port maskReg  input  4  per-channel hardware-request mask, 1 = masked.
REQ-009 SHALL have port reqReg  input  4  software request bits, never masked.
REQ-010 SHALL have port hrq  input  1  hold request from timing control.
REQ-011 SHALL have port validDACK  input  1  timing control indicates granted channel is in service.
REQ-012 SHALL have ports VALID_DREQ0..VALID_DREQ3  output  1 each  one-hot granted channel to timing control/datapath.
REQ-013 SHALL have port DACK  output  4  channel acknowledges, polarity per cmdDackSenseHigh.
REQ-014 SHALL have port reqStatus  output  4  registered unmasked request bits for status register.

Function
REQ-015 SHALL register DREQ once (1-cycle sample) and normalise to active-high using cmdDreqSenseLow.
REQ-016 SHALL form effReq[i] = (sampledReq[i] & ~maskReg[i]) | reqReg[i].
REQ-017 SHALL drive reqStatus = sampledReq | reqReg, independent of maskReg.
REQ-018 SHALL implement states IDLE, GRANT, SERVICE.
REQ-019 IDLE: if cmdDisable=0 and effReq!=0, latch highest-priority requester, go GRANT; VALID_DREQn high the cycle after the decision.
REQ-020 Priority SHALL be searched from 2-bit pointer ptr upward, modulo 4 (ptr=3 order 3,0,1,2).
REQ-021 GRANT: validDACK=1 -> SERVICE; granted channel's effReq falls while validDACK=0 -> IDLE, grant cleared, ptr unchanged.
REQ-022 SERVICE: grant held regardless of DREQ, mask or cmdDisable changes; validDACK=0 -> IDLE.
REQ-023 On SERVICE->IDLE with cmdRotate=1, ptr SHALL become (ch+1) mod 4; with cmdRotate=0, ptr SHALL be 0.
REQ-024 cmdRotate 1->0 SHALL force ptr=0 on the next edge without disturbing an active grant.
REQ-025 At most one VALID_DREQn SHALL be high in any cycle; all low in IDLE.
REQ-026 DACK[ch] SHALL be active only in SERVICE for the granted channel; inactive level = ~cmdDackSenseHigh (combinational polarity).
REQ-027 Simultaneous requests SHALL resolve in one cycle; a new grant SHALL not be issued in the same cycle SERVICE exits (minimum one IDLE cycle).
REQ-028 hrq is informational only; arbitration SHALL not depend on it.

Reset
REQ-029 RESET=0 SHALL force state=IDLE, ptr=0, grant=0, sampled DREQ=0, reqStatus=0, all VALID_DREQn=0.
REQ-030 Reset asserted mid-SERVICE SHALL drop grant and DACK to inactive on the next edge; no rotation update.

Structure
REQ-031 Package dma_pkg SHALL hold state enum, NUM_CH=4 and the channel-index/pointer type.
REQ-032 Rotating search SHALL be a combinational sub-module dma_prio_encoder (effReq, ptr -> one-hot, valid).

Verification
REQ-033 Fixed mode, DREQ=4'b1010 active-high, mask=0 -> VALID_DREQ1 high two cycles later; validDACK pulse -> DACK[1] active; ptr stays 0.
REQ-034 Rotate mode, serve ch2 then DREQ=4'b1111 -> next grant ch3, then ch0 after ch3 served (wrap 3->0).
REQ-035 maskReg=4'b0001, DREQ0 high, reqReg=4'b0001 -> ch0 granted; reqReg=0 -> no grant, reqStatus[0]=1.
REQ-036 Grant ch1, drop DREQ1 before validDACK -> return IDLE, VALID_DREQ1 low, ptr unchanged.
REQ-037 cmdDisable=1 during SERVICE -> service completes; new requests ignored until cmdDisable=0.
REQ-038 RESET=0 in SERVICE with cmdDackSenseHigh=0 -> DACK=4'b1111 and VALID_DREQn=0 next edge.
